// File: rtl/nr_div_pkg.sv
// Shared definitions for the sequential non-restoring divider.
// Holds the controller state type and the default operand width.
// No ports; imported by nr_divider_seq.
package nr_div_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ITER    = 2'd1,
      CORRECT = 2'd2
   } state_t;

endpackage

// File: rtl/nr_addsub.sv
// Controlled N-bit adder/subtractor for the non-restoring datapath.
// Ports: a, b operands; sub selects a-b (1) or a+b (0).
//        sum is the N-bit two's complement result; sign is its MSB.
module nr_addsub #(
   parameter int N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N-1:0] sum,
   output logic         sign
);

   assign sum  = sub ? (a - b) : (a + b);
   assign sign = sum[N-1];

endmodule

// File: rtl/nr_divider_seq.sv
// Sequential unsigned divider using a non-restoring step, one quotient bit per cycle.
// Ports: clk, rst (async active-high), start/dividend/divisor request;
//        busy, done pulse, registered quotient/remainder and div_by_zero flag.
module nr_divider_seq
   import nr_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state, state_nx;
   logic [WIDTH:0]   p;        // partial remainder, two's complement
   logic [WIDTH-1:0] q;        // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] d;
   logic             zero;
   logic [CW-1:0]    cnt;
   logic             cap_en, iter_en, fin_en;
   logic [WIDTH:0]   as_a, as_b, as_sum;
   logic             as_sub, as_sign;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic; a zero divisor bypasses the iterations entirely
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (divisor == '0) ? CORRECT : ITER;
         ITER:    if (cnt == LAST) state_nx = CORRECT;
         CORRECT: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      cap_en  = 1'b0;
      iter_en = 1'b0;
      fin_en  = 1'b0;
      case (state)
         IDLE:    cap_en  = start;
         ITER:    iter_en = 1'b1;
         CORRECT: fin_en  = 1'b1;
         default: ;
      endcase
   end

   assign busy = (state != IDLE);

   // One adder serves both phases: in ITER it takes the shifted {P,Q} MSB and
   // subtracts when P was non-negative; in CORRECT it adds D back to P.
   assign as_a   = iter_en ? {p[WIDTH-1:0], q[WIDTH-1]} : p;
   assign as_b   = {1'b0, d};
   assign as_sub = iter_en & ~p[WIDTH];

   nr_addsub #(.N(WIDTH + 1)) u_addsub (
      .a    (as_a),
      .b    (as_b),
      .sub  (as_sub),
      .sum  (as_sum),
      .sign (as_sign)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p           <= '0;
         q           <= '0;
         d           <= '0;
         zero        <= 1'b0;
         cnt         <= '0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= fin_en;
         if (cap_en) begin
            p    <= '0;
            q    <= dividend;
            d    <= divisor;
            zero <= (divisor == '0);
            cnt  <= '0;
         end else if (iter_en) begin
            p   <= as_sum;
            q   <= {q[WIDTH-2:0], ~as_sign};
            cnt <= cnt + CW'(1);
         end
         if (fin_en) begin
            div_by_zero <= zero;
            if (zero) begin
               // q still holds the untouched dividend
               quotient  <= '1;
               remainder <= q;
            end else begin
               quotient  <= q;
               remainder <= p[WIDTH] ? as_sum[WIDTH-1:0] : p[WIDTH-1:0];
            end
         end
      end
   end

endmodule

// File: doc/nr_divider_seq.md
NR_DIVIDER_SEQ -- requirements
Module: nr_divider_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dividend  input  WIDTH  unsigned dividend; sampled with start.
REQ-006 divisor  input  WIDTH  unsigned divisor; sampled with start.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse; results valid.
REQ-009 quotient  output  WIDTH  unsigned quotient, registered.
REQ-010 remainder  output  WIDTH  unsigned corrected remainder, registered.
REQ-011 div_by_zero  output  1  high with done when the sampled divisor was 0.

Function
REQ-012 The FSM SHALL have states IDLE, ITER, CORRECT.
REQ-013 IDLE with start=1 SHALL capture operands, clear the partial remainder P (WIDTH+1 bits, two's complement) and the iteration counter, and go to ITER; busy rises at that edge.
REQ-014 start SHALL be ignored outside IDLE; operand inputs are don't-care outside the capture edge.
REQ-015 Each ITER cycle SHALL perform one non-restoring step: shift {P,Q} left one bit; P = P-D if P was >=0 before the shift, else P = P+D; new quotient LSB = 1 if the result is >=0, else 0.
REQ-016 ITER SHALL last exactly WIDTH cycles, then go to CORRECT.
REQ-017 CORRECT SHALL add D to P when P<0 (remainder correction), else pass P unchanged; it SHALL register quotient/remainder, pulse done, drop busy and return to IDLE, all at the same edge.
REQ-018 Latency: start sampled at edge k -> done high between edges k+WIDTH+1 and k+WIDTH+2.
REQ-019 A new start SHALL be accepted in the cycle in which done is high (back-to-back operation).
REQ-020 Divisor 0: the block SHALL skip ITER; at edge k+1 quotient = all ones, remainder = dividend, div_by_zero=1 and done=1 for one cycle.
REQ-021 quotient, remainder and div_by_zero SHALL hold their values until the next done; div_by_zero clears at the next done without the zero-divisor condition.
REQ-022 The corrected remainder SHALL always satisfy 0 <= remainder < divisor, and dividend = quotient*divisor + remainder, for every divisor != 0.

Reset
REQ-023 rst=1 SHALL immediately force IDLE and set busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0, P=0.
REQ-024 Reset asserted mid-division SHALL abort the operation with no done pulse; the first start after deassertion SHALL be serviced normally.

Structure
REQ-025 Package nr_div_pkg SHALL hold the state enum type and the default WIDTH constant.
REQ-026 The (WIDTH+1)-bit controlled add/subtract SHALL be one sub-module, nr_addsub (inputs a, b, sub; outputs sum, sign), used for both the ITER step and the CORRECT step.
REQ-027 Counter width SHALL be $clog2(WIDTH+1).

Verification
REQ-028 WIDTH=8, 100/7 -> done at k+9, quotient=14, remainder=2, div_by_zero=0.
REQ-029 WIDTH=4, 13/3 -> quotient=4, remainder=1 (final P negative, correction add exercised); 15/1 -> 15, 0.
REQ-030 WIDTH=8, 42/0 -> done at k+1, quotient=255, remainder=42, div_by_zero=1; next 9/3 -> 3, 0, div_by_zero=0.
REQ-031 WIDTH=8, 5/10 -> quotient=0, remainder=5; start pulsed again at k+3 with 200/2 -> ignored, results still 0/5.
REQ-032 WIDTH=8, 255/16 started; rst pulsed at k+4 -> all outputs 0, no done; start 255/16 after reset -> 15, 15.
REQ-033 WIDTH=16 random unsigned operands, back-to-back starts on the done cycle -> every result matches the golden model, no lost or extra done.
